// File: rtl/axis_pulse_train_gen_if.sv
// Pulse-train generator bus: trigger and configuration in, gate and status out.
// The master side (trigger source / register bank) drives trig and cfg_*,
// the slave side (the generator) drives gate, busy, done and sts_pulses.
interface axis_pulse_train_gen_if #(
    parameter int CNTR_WIDTH = 32,
    parameter int NUM_WIDTH  = 16
);
    logic                  trig;
    logic [CNTR_WIDTH-1:0] cfg_delay;
    logic [CNTR_WIDTH-1:0] cfg_width;
    logic [CNTR_WIDTH-1:0] cfg_period;
    logic [NUM_WIDTH-1:0]  cfg_count;
    logic                  gate;
    logic                  busy;
    logic                  done;
    logic [NUM_WIDTH-1:0]  sts_pulses;

    modport master (
        output trig, cfg_delay, cfg_width, cfg_period, cfg_count,
        input  gate, busy, done, sts_pulses
    );

    modport slave (
        input  trig, cfg_delay, cfg_width, cfg_period, cfg_count,
        output gate, busy, done, sts_pulses
    );
endinterface

// File: rtl/axis_pulse_train_gen.sv
// Triggered gate pulse-train generator.
// On an accepted trigger: wait cfg_delay cycles, then emit cfg_count gate
// pulses of cfg_width cycles with cfg_period rise-to-rise spacing.
// Optional macro PULSE_TRAIN_RETRIG_EN: a trigger while busy restarts the train.
module axis_pulse_train_gen #(
    parameter int CNTR_WIDTH = 32,
    parameter int NUM_WIDTH  = 16
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    axis_pulse_train_gen_if.slave       bus
);

    typedef enum logic [1:0] {IDLE, DELAY, HIGH, LOW} state_t;

    localparam logic [CNTR_WIDTH-1:0] T_ONE = CNTR_WIDTH'(1);
    localparam logic [NUM_WIDTH-1:0]  N_ONE = NUM_WIDTH'(1);

    state_t                state, state_n;
    logic [CNTR_WIDTH-1:0] timer, timer_n;
    logic [CNTR_WIDTH-1:0] sh_width, sh_width_n;
    logic [CNTR_WIDTH-1:0] sh_low, sh_low_n;
    logic [NUM_WIDTH-1:0]  remain, remain_n;
    logic [NUM_WIDTH-1:0]  pulses, pulses_n;
    logic                  done_n;
    logic                  gate_q, busy_q, done_q;
    logic                  cfg_ok, start;

    // A zero width or zero count describes no train at all; such triggers are dropped.
    always_comb cfg_ok = (bus.cfg_width != '0) && (bus.cfg_count != '0);

`ifdef PULSE_TRAIN_RETRIG_EN
    // Any valid trigger (re)starts the train, aborting one in progress without done.
    always_comb start = bus.trig && cfg_ok;
`else
    // Triggers are only honoured between trains.
    always_comb start = bus.trig && cfg_ok && (state == IDLE);
`endif

    // Next-state logic: timers count down to 1, so a load of N gives exactly N cycles.
    always_comb begin
        state_n    = state;
        timer_n    = timer;
        sh_width_n = sh_width;
        sh_low_n   = sh_low;
        remain_n   = remain;
        pulses_n   = pulses;
        done_n     = 1'b0;
        if (start) begin
            // Low phase is precomputed at latch time; it never drops below one cycle.
            sh_width_n = bus.cfg_width;
            sh_low_n   = (bus.cfg_period > bus.cfg_width) ? (bus.cfg_period - bus.cfg_width) : T_ONE;
            remain_n   = bus.cfg_count;
            pulses_n   = '0;
            if (bus.cfg_delay != '0) begin
                state_n = DELAY;
                timer_n = bus.cfg_delay;
            end else begin
                state_n = HIGH;
                timer_n = bus.cfg_width;
            end
        end else begin
            case (state)
                DELAY: begin
                    if (timer == T_ONE) begin
                        state_n = HIGH;
                        timer_n = sh_width;
                    end else begin
                        timer_n = timer - T_ONE;
                    end
                end
                HIGH: begin
                    if (timer == T_ONE) begin
                        pulses_n = pulses + N_ONE;
                        if (remain == N_ONE) begin
                            state_n = IDLE;
                            done_n  = 1'b1;
                        end else begin
                            state_n  = LOW;
                            timer_n  = sh_low;
                            remain_n = remain - N_ONE;
                        end
                    end else begin
                        timer_n = timer - T_ONE;
                    end
                end
                LOW: begin
                    if (timer == T_ONE) begin
                        state_n = HIGH;
                        timer_n = sh_width;
                    end else begin
                        timer_n = timer - T_ONE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // State, timers and outputs register together so all outputs track the state.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state    <= IDLE;
            timer    <= '0;
            sh_width <= '0;
            sh_low   <= '0;
            remain   <= '0;
            pulses   <= '0;
            gate_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_n;
            timer    <= timer_n;
            sh_width <= sh_width_n;
            sh_low   <= sh_low_n;
            remain   <= remain_n;
            pulses   <= pulses_n;
            gate_q   <= (state_n == HIGH);
            busy_q   <= (state_n != IDLE);
            done_q   <= done_n;
        end
    end

    assign bus.gate       = gate_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.sts_pulses = pulses;

endmodule
